// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the mux select arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } arb_state_e;

    localparam int MAX_HOLD_DEF = 8;
    localparam int CW_DEF       = 4;

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the two requesters and the mux select arbiter.
interface mux_sel_arbiter_if;
    logic req_a;
    logic req_b;
    logic done;
    logic s;
    logic gnt_a;
    logic gnt_b;
    logic busy;

    modport master (output req_a, req_b, done, input s, gnt_a, gnt_b, busy);
    modport slave  (input req_a, req_b, done, output s, gnt_a, gnt_b, busy);
endinterface

// File: rtl/mux_sel_arbiter_hold_counter.sv
// Saturating hold counter; tc flags the last cycle a contested grant may be held.
module hold_counter #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == CW'(MAX_HOLD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !tc_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin 2-way arbiter driving a glitch-free 2:1 mux select with a hold limit.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_sel_arbiter_if.slave bus
);

    arb_state_e state_q, state_d;
    logic last_q, last_d;
    logic s_q, s_d;
    logic gnt_a_q, gnt_a_d;
    logic gnt_b_q, gnt_b_d;
    logic busy_q, busy_d;
    logic hold_clr, hold_en, hold_tc;

    hold_counter #(.MAX_HOLD(MAX_HOLD), .CW(CW)) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (hold_clr),
        .en_i  (hold_en),
        .tc_o  (hold_tc)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // last=1 means B was served last, so A wins the tie
                if (bus.req_a && bus.req_b) state_d = last_q ? GRANT_A : GRANT_B;
                else if (bus.req_a)         state_d = GRANT_A;
                else if (bus.req_b)         state_d = GRANT_B;
            end
            GRANT_A: begin
                if (bus.done || !bus.req_a || (hold_tc && bus.req_b)) begin
                    last_d  = 1'b0;
                    state_d = bus.req_b ? GRANT_B : IDLE;
                end
            end
            GRANT_B: begin
                if (bus.done || !bus.req_b || (hold_tc && bus.req_a)) begin
                    last_d  = 1'b1;
                    state_d = bus.req_a ? GRANT_A : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs come from flops loaded with the next-state decode
        gnt_a_d = (state_d == GRANT_A);
        gnt_b_d = (state_d == GRANT_B);
        busy_d  = gnt_a_d | gnt_b_d;
        s_d     = gnt_b_d ? 1'b1 : (gnt_a_d ? 1'b0 : s_q);

        hold_clr = (state_d != IDLE) && (state_d != state_q);
        hold_en  = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            s_q     <= 1'b0;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            s_q     <= s_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.s     = s_q;
    assign bus.gnt_a = gnt_a_q;
    assign bus.gnt_b = gnt_b_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed scoreboard bench for mux_sel_arbiter; outputs packed as {s,gnt_a,gnt_b,busy}.
module tb_mux_sel_arbiter;

    localparam logic [3:0] IDL0 = 4'b0000;
    localparam logic [3:0] IDL1 = 4'b1000;
    localparam logic [3:0] GA   = 4'b0101;
    localparam logic [3:0] GB   = 4'b1011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_sel_arbiter_if bus ();

    mux_sel_arbiter #(.MAX_HOLD(8), .CW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    wire [3:0] obs = {bus.s, bus.gnt_a, bus.gnt_b, bus.busy};

    function automatic void check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {s,ga,gb,busy}=%b expected %b", name, act, exp);
        end
    endfunction

    // Monitor: one registered-output sample per cycle, compared against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check(e.name, obs, e.exp);
        end
    end

    task automatic step(input logic ra, input logic rb, input logic dn,
                        input logic [3:0] exp, input string name);
        bus.req_a = ra;
        bus.req_b = rb;
        bus.done  = dn;
        @(posedge clk);
        sb.push_back('{exp, name});
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d pending expected 0", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        bus.done  = 1'b0;
        #1 check("reset_immediate", obs, IDL0);
        repeat (2) @(negedge clk);
        check("reset_held", obs, IDL0);
        rst_n = 1'b1;

        // Tie after reset goes to A, then contested timeouts of 8 cycles each
        for (int i = 0; i < 8; i++) step(1, 1, 0, GA, "timeout_a");
        for (int i = 0; i < 8; i++) step(1, 1, 0, GB, "timeout_b");
        step(1, 1, 0, GA, "timeout_back_a");

        // done every third cycle: handoffs with no idle gap
        step(1, 1, 0, GA, "alt_a");
        step(1, 1, 1, GB, "alt_to_b");
        step(1, 1, 0, GB, "alt_b");
        step(1, 1, 0, GB, "alt_b");
        step(1, 1, 1, GA, "alt_to_a");
        step(1, 1, 0, GA, "alt_a");
        step(1, 1, 0, GA, "alt_a");
        step(1, 1, 1, GB, "alt_to_b2");

        // B drops: idle with s held at 1; done in idle ignored
        step(0, 0, 0, IDL1, "b_release_idle");
        for (int i = 0; i < 3; i++) step(0, 0, 0, IDL1, "s_hold_idle");
        step(0, 0, 1, IDL1, "done_in_idle");

        // Uncontested A for 20 cycles, then release
        for (int i = 0; i < 20; i++) step(1, 0, 0, GA, "uncontested_a");
        step(0, 0, 0, IDL0, "a_release_idle");
        step(0, 0, 0, IDL0, "idle_s0");
        step(1, 1, 0, GB, "tie_after_a_goes_b");

        // Asynchronous reset in the middle of a B grant
        #2 rst_n = 1'b0;
        #1 check("async_reset_mid_grant", obs, IDL0);
        repeat (2) @(negedge clk);
        check("reset_low_held", obs, IDL0);
        rst_n = 1'b1;
        step(1, 1, 0, GA, "tie_after_reset_a");

        // done coincides with timeout: single release to B
        for (int i = 0; i < 7; i++) step(1, 1, 0, GA, "pre_timeout_a");
        step(1, 1, 1, GB, "done_and_timeout");

        // B drops while A requests: direct handoff
        step(1, 0, 0, GA, "b_drop_handoff");
        step(1, 1, 0, GA, "a_hold");
        step(1, 0, 1, IDL0, "done_no_other");
        step(1, 0, 0, GA, "regrant_a");

        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
